// File: rtl/decoder_3to8_strobe_if.sv
// Code-input handshake for the strobe decoder: the source drives a 3-bit select code with valid,
// and the decoder answers with ready.
interface decoder_3to8_strobe_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/decoder_3to8_strobe.sv
// Queued 3-to-8 one-hot decoder: each accepted code becomes a stretched one-hot strobe,
// followed by at least one all-zero gap cycle.
//
// state | meaning
// IDLE  | nothing driven; waits for a queued code with en high
// DRIVE | Y holds one-hot of the popped code while the hold counter runs down
// GAP   | one zero cycle with done high; may pop the next code immediately
module decoder_3to8_strobe #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  decoder_3to8_strobe_if.slave        in_bus,
  input  logic                        en,
  output logic [7:0]                  Y,
  output logic                        y_valid,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      y_d;
  logic            yv_d, done_d;
  logic            push, pop;
  logic [2:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      head;

  // No full-bypass: a pop in the same cycle does not open the door when full.
  assign in_bus.in_ready = !rst && (count < FULL_CNT);
  assign push            = in_bus.in_valid && in_bus.in_ready;
  assign head            = mem[rd_ptr];
  assign busy            = (state_q != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bus.in_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      Y       <= '0;
      y_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      Y       <= y_d;
      y_valid <= yv_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_d     = Y;
    yv_d    = y_valid;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if ((count != '0) && en) begin
          pop     = 1'b1;
          y_d     = 8'b1 << head;
          yv_d    = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        // en low freezes the strobe, stretching it by one cycle per paused cycle.
        if (en) begin
          if (hold_q == '0) begin
            y_d     = '0;
            yv_d    = 1'b0;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Directed bench for decoder_3to8_strobe with HOLD_CYCLES=4, FIFO_DEPTH=4; expected values are
// hand-computed per cycle.
module tb_decoder_3to8_strobe;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] Y;
  logic       y_valid;
  logic       done;
  logic [2:0] count;
  logic       busy;
  int         n_checks = 0;
  int         n_pass   = 0;

  decoder_3to8_strobe_if bus();

  decoder_3to8_strobe #(.HOLD_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (bus),
    .en      (en),
    .Y       (Y),
    .y_valid (y_valid),
    .done    (done),
    .count   (count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance n cycles, checking Y, y_valid and done after each edge.
  task automatic run_y(input string tag, input logic [7:0] exp_y, input logic exp_done, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_y"},    32'(Y),       32'(exp_y));
      chk({tag, "_yv"},   32'(y_valid), 32'(exp_y != 8'h00));
      chk({tag, "_done"}, 32'(done),    32'(exp_done));
    end
  endtask

  task automatic push_one(input logic [2:0] code);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_code  = 3'd0;
    @(negedge clk);
    step();
    chk("rst_y",     32'(Y),            32'h0);
    chk("rst_yv",    32'(y_valid),      32'h0);
    chk("rst_done",  32'(done),         32'h0);
    chk("rst_count", 32'(count),        32'h0);
    chk("rst_busy",  32'(busy),         32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);

    // single strobe of code 5
    push_one(3'd5);
    chk("t1_count", 32'(count), 32'h1);
    chk("t1_y0",    32'(Y),     32'h0);
    run_y("t1_hold", 8'h20, 1'b0, 4);
    run_y("t1_gap",  8'h00, 1'b1, 1);
    chk("t1_gap_busy", 32'(busy), 32'h1);
    run_y("t1_idle", 8'h00, 1'b0, 1);
    chk("t1_busy", 32'(busy), 32'h0);

    // back-to-back codes 0 then 7
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd0;
    step();
    bus.in_code  = 3'd7;
    step();
    bus.in_valid = 1'b0;
    chk("t2_y_first", 32'(Y),     32'h01);
    chk("t2_count",   32'(count), 32'h1);
    run_y("t2_a",    8'h01, 1'b0, 3);
    run_y("t2_gap1", 8'h00, 1'b1, 1);
    run_y("t2_b",    8'h80, 1'b0, 4);
    run_y("t2_gap2", 8'h00, 1'b1, 1);
    run_y("t2_idle", 8'h00, 1'b0, 1);

    // fill the queue with en low; fifth push is held off
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_fill", 32'(bus.in_ready), 32'h1);
      bus.in_valid = 1'b1;
      bus.in_code  = 3'(i);
      step();
    end
    bus.in_code = 3'd4;
    chk("t3_count_full", 32'(count),        32'h4);
    chk("t3_ready_full", 32'(bus.in_ready), 32'h0);
    step();
    step();
    chk("t3_count_held", 32'(count), 32'h4);
    chk("t3_y_held",     32'(Y),     32'h0);
    en = 1'b1;
    step();
    chk("t3_y_pop0",  32'(Y),            32'h01);
    chk("t3_count3",  32'(count),        32'h3);
    chk("t3_ready3",  32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0;
    chk("t3_count_refill", 32'(count), 32'h4);
    chk("t3_y_still0",     32'(Y),     32'h01);
    run_y("t3_s0", 8'h01, 1'b0, 2);
    run_y("t3_g0", 8'h00, 1'b1, 1);
    run_y("t3_s1", 8'h02, 1'b0, 4);
    run_y("t3_g1", 8'h00, 1'b1, 1);
    run_y("t3_s2", 8'h04, 1'b0, 4);
    run_y("t3_g2", 8'h00, 1'b1, 1);
    run_y("t3_s3", 8'h08, 1'b0, 4);
    run_y("t3_g3", 8'h00, 1'b1, 1);
    run_y("t3_s4", 8'h10, 1'b0, 4);
    run_y("t3_g4", 8'h00, 1'b1, 1);
    run_y("t3_idle", 8'h00, 1'b0, 1);
    chk("t3_count_end", 32'(count), 32'h0);
    chk("t3_busy_end",  32'(busy),  32'h0);

    // pause 3 cycles during DRIVE of code 2: 7 cycles high in total
    push_one(3'd2);
    step();
    chk("t4_y_start", 32'(Y), 32'h04);
    run_y("t4_pre",    8'h04, 1'b0, 1);
    en = 1'b0;
    run_y("t4_pause",  8'h04, 1'b0, 3);
    en = 1'b1;
    run_y("t4_resume", 8'h04, 1'b0, 2);
    run_y("t4_gap",    8'h00, 1'b1, 1);
    run_y("t4_idle",   8'h00, 1'b0, 1);

    // reset mid-DRIVE with two codes still queued
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd1;
    step();
    bus.in_code  = 3'd2;
    step();
    bus.in_code  = 3'd3;
    step();
    bus.in_valid = 1'b0;
    chk("t5_y_drive", 32'(Y),     32'h02);
    chk("t5_count2",  32'(count), 32'h2);
    rst = 1'b1;
    step();
    chk("t5_y",     32'(Y),            32'h0);
    chk("t5_count", 32'(count),        32'h0);
    chk("t5_done",  32'(done),         32'h0);
    chk("t5_busy",  32'(busy),         32'h0);
    chk("t5_ready", 32'(bus.in_ready), 32'h0);
    rst = 1'b0;
    run_y("t5_quiet", 8'h00, 1'b0, 6);
    chk("t5_count_after", 32'(count), 32'h0);

    // identical consecutive codes give two strobes with one zero cycle between
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd3;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("t6_y_first", 32'(Y), 32'h08);
    run_y("t6_a",    8'h08, 1'b0, 3);
    run_y("t6_gap",  8'h00, 1'b1, 1);
    run_y("t6_b",    8'h08, 1'b0, 4);
    run_y("t6_gap2", 8'h00, 1'b1, 1);
    run_y("t6_idle", 8'h00, 1'b0, 1);
    chk("t6_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
